// File: rtl/rf_wb_arb_if.sv
// rtl/rf_wb_arb_if.sv - pipeline/LSU writeback and RF write-port bundle for rf_wb_arb
interface rf_wb_arb_if;
  logic        pipe_we;
  logic [4:0]  pipe_wR;
  logic [31:0] pipe_wD;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_wR;
  logic [31:0] lsu_wD;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic [31:0] pend;
  logic        empty;

  modport master (
    output pipe_we, pipe_wR, pipe_wD, lsu_valid, lsu_wR, lsu_wD,
    input  lsu_ready, rf_we, rf_wR, rf_wD, pend, empty
  );

  modport slave (
    input  pipe_we, pipe_wR, pipe_wD, lsu_valid, lsu_wR, lsu_wD,
    output lsu_ready, rf_we, rf_wR, rf_wD, pend, empty
  );
endinterface

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - RF write-port arbiter: pipeline has priority, LSU results queue in a FIFO.
// Define RF_WB_PEND_EN to build the pending-write bitmap; otherwise pend is tied to zero.
module rf_wb_arb #(
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  rf_wb_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    wr_q [DEPTH];
  logic [31:0]   wd_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_wR_q, rf_wR_d;
  logic [31:0]   rf_wD_q, rf_wD_d;
  logic          full, slot_busy, push, pop;

  assign full      = (count_q == FULL_CNT);
  assign slot_busy = bus.pipe_we && (bus.pipe_wR != 5'd0);
  assign pop       = !slot_busy && (count_q != '0);
  // x0 writes complete the handshake but never occupy a FIFO entry
  assign push      = bus.lsu_valid && bus.lsu_ready && (bus.lsu_wR != 5'd0);

  assign bus.lsu_ready = !rst && !full;
  assign bus.empty     = (count_q == '0);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wR     = rf_wR_q;
  assign bus.rf_wD     = rf_wD_q;

  always_comb begin
    rf_we_d = slot_busy || pop;
    rf_wR_d = rf_wR_q;
    rf_wD_d = rf_wD_q;
    if (slot_busy) begin
      rf_wR_d = bus.pipe_wR;
      rf_wD_d = bus.pipe_wD;
    end else if (pop) begin
      rf_wR_d = wr_q[head_q];
      rf_wD_d = wd_q[head_q];
    end
    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rf_we_q <= 1'b0;
      rf_wR_q <= '0;
      rf_wD_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rf_we_q <= rf_we_d;
      rf_wR_q <= rf_wR_d;
      rf_wD_q <= rf_wD_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count alone
  always_ff @(posedge clk) begin
    if (push) begin
      wr_q[tail_q] <= bus.lsu_wR;
      wd_q[tail_q] <= bus.lsu_wD;
    end
  end

`ifdef RF_WB_PEND_EN
  logic [31:0]   pend_c;
  logic [AW-1:0] off;

  // Slot i is live when its distance from head (mod DEPTH) is below the occupancy
  always_comb begin
    pend_c = '0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if ({1'b0, off} < count_q) begin
        pend_c[wr_q[i]] = 1'b1;
      end
    end
    pend_c[0] = 1'b0;
  end

  assign bus.pend = pend_c;
`else
  assign bus.pend = 32'b0;
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - directed bench for rf_wb_arb with a queue-based reference model.
module tb_rf_wb_arb;
  localparam int DEPTH = 4;
`ifdef RF_WB_PEND_EN
  localparam logic [31:0] PEND_BP = 32'h0000_3C00;
  localparam logic [31:0] PEND_X7 = 32'h0000_0080;
`else
  localparam logic [31:0] PEND_BP = 32'h0;
  localparam logic [31:0] PEND_X7 = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  rf_wb_arb_if bus();

  rf_wb_arb #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wr = 5'd0;
  logic [31:0] m_wd = 32'd0;
  int          max_occ = 0;
  logic [4:0]  wlog[$];
  logic [31:0] dlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
`ifdef RF_WB_PEND_EN
    foreach (mq[i]) p[mq[i].wr] = 1'b1;
    p[0] = 1'b0;
`endif
    return p;
  endfunction

  // Reference model: pipeline wins the slot, otherwise the oldest queued LSU write goes out
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_we = 1'b0;
      m_wr = 5'd0;
      m_wd = 32'd0;
    end else begin
      bit   acc;
      ent_t e;
      acc = bus.lsu_valid && (mq.size() < DEPTH);
      if (bus.pipe_we && bus.pipe_wR != 5'd0) begin
        m_we = 1'b1;
        m_wr = bus.pipe_wR;
        m_wd = bus.pipe_wD;
      end else if (mq.size() > 0) begin
        e    = mq.pop_front();
        m_we = 1'b1;
        m_wr = e.wr;
        m_wd = e.wd;
      end else begin
        m_we = 1'b0;
      end
      if (acc && bus.lsu_wR != 5'd0) begin
        e.wr = bus.lsu_wR;
        e.wd = bus.lsu_wD;
        mq.push_back(e);
      end
      if (mq.size() > max_occ) max_occ = mq.size();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
      chk("rf_wR", {27'd0, bus.rf_wR}, {27'd0, m_wr});
      chk("rf_wD", bus.rf_wD, m_wd);
      chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, (!rst && mq.size() < DEPTH)});
      chk("empty", {31'd0, bus.empty}, {31'd0, (mq.size() == 0)});
      chk("pend", bus.pend, m_pend());
      if (!rst && bus.rf_we === 1'b1) begin
        wlog.push_back(bus.rf_wR);
        dlog.push_back(bus.rf_wD);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    bit hs;
    bus.pipe_we   = 1'b0;
    bus.pipe_wR   = 5'd0;
    bus.pipe_wD   = 32'd0;
    bus.lsu_valid = 1'b0;
    bus.lsu_wR    = 5'd0;
    bus.lsu_wD    = 32'd0;

    tick();
    cmp_en = 1'b1;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    tick();

    // Pipeline only
    bus.pipe_we = 1'b1;
    bus.pipe_wR = 5'd5;
    bus.pipe_wD = 32'hDEAD_BEEF;
    tick();
    chk("pipe_we", {31'd0, bus.rf_we}, 32'd1);
    chk("pipe_wR", {27'd0, bus.rf_wR}, 32'd5);
    chk("pipe_wD", bus.rf_wD, 32'hDEAD_BEEF);
    bus.pipe_wR = 5'd0;
    tick();
    chk("pipe_x0_we", {31'd0, bus.rf_we}, 32'd0);
    chk("pipe_x0_hold", {27'd0, bus.rf_wR}, 32'd5);
    bus.pipe_we = 1'b0;

    // LSU with a free slot
    bus.lsu_valid = 1'b1;
    bus.lsu_wR    = 5'd7;
    bus.lsu_wD    = 32'h1234_5678;
    tick();
    bus.lsu_valid = 1'b0;
    chk("lsu_pend7", bus.pend, PEND_X7);
    chk("lsu_q_we", {31'd0, bus.rf_we}, 32'd0);
    tick();
    chk("lsu_we", {31'd0, bus.rf_we}, 32'd1);
    chk("lsu_wR", {27'd0, bus.rf_wR}, 32'd7);
    chk("lsu_wD", bus.rf_wD, 32'h1234_5678);
    chk("lsu_pend_clr", bus.pend, 32'd0);
    tick();

    // Priority and back-pressure
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_wR   = 5'(1 + i);
      bus.pipe_wD   = 32'(i);
      bus.lsu_valid = 1'b1;
      bus.lsu_wR    = 5'(10 + acc);
      bus.lsu_wD    = 32'hA0 + 32'(acc);
      hs = bus.lsu_ready;
      tick();
      if (hs) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_ready", {31'd0, bus.lsu_ready}, 32'd0);
    chk("bp_pend", bus.pend, PEND_BP);
    bus.pipe_we   = 1'b0;
    bus.lsu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_drain_we", {31'd0, bus.rf_we}, 32'd1);
      chk("bp_drain_wR", {27'd0, bus.rf_wR}, 32'(10 + k));
      chk("bp_drain_wD", bus.rf_wD, 32'hA0 + 32'(k));
      if (k == 0) chk("bp_ready_back", {31'd0, bus.lsu_ready}, 32'd1);
    end
    tick();
    chk("bp_idle_we", {31'd0, bus.rf_we}, 32'd0);
    chk("bp_empty", {31'd0, bus.empty}, 32'd1);

    // Streaming through the pointer wrap
    wlog.delete();
    dlog.delete();
    max_occ = 0;
    for (int i = 0; i < 10; i++) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_wR    = 5'(16 + i);
      bus.lsu_wD    = 32'h100 + 32'(i);
      tick();
    end
    bus.lsu_valid = 1'b0;
    tick();
    tick();
    chk("stream_count", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) begin
      chk("stream_wR", {27'd0, wlog[i]}, 32'(16 + i));
      chk("stream_wD", dlog[i], 32'h100 + 32'(i));
    end
    chk("stream_max_occ", 32'(max_occ), 32'd1);

    // x0 from the LSU is accepted and dropped
    bus.lsu_valid = 1'b1;
    bus.lsu_wR    = 5'd0;
    bus.lsu_wD    = 32'h5555_AAAA;
    chk("x0_ready", {31'd0, bus.lsu_ready}, 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    chk("x0_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    chk("x0_no_write", {31'd0, bus.rf_we}, 32'd0);

    // Reset with three entries queued
    bus.pipe_we = 1'b1;
    bus.pipe_wR = 5'd2;
    bus.pipe_wD = 32'h2222;
    for (int i = 0; i < 3; i++) begin
      bus.lsu_valid = 1'b1;
      bus.lsu_wR    = 5'(3 + i);
      bus.lsu_wD    = 32'h300 + 32'(i);
      tick();
    end
    bus.lsu_valid = 1'b0;
    chk("mid_not_empty", {31'd0, bus.empty}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
    chk("mid_rst_wR", {27'd0, bus.rf_wR}, 32'd0);
    chk("mid_rst_wD", bus.rf_wD, 32'd0);
    chk("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("mid_rst_pend", bus.pend, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.lsu_ready}, 32'd0);
    tick();
    rst = 1'b0;
    bus.pipe_we = 1'b0;
    #1;
    chk("mid_rel_ready", {31'd0, bus.lsu_ready}, 32'd1);
    tick();
    chk("mid_rel_we", {31'd0, bus.rf_we}, 32'd0);
    chk("mid_rel_empty", {31'd0, bus.empty}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
